// File: rtl/sdram_port_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the SDRAM controller.
// The arbiter connects through "slave"; the requesters and controller together form "master".
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic [1:0]        p0_bsel;
    logic              p0_ack;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic [1:0]        p1_bsel;
    logic              p1_ack;
    logic [DATA_W-1:0] p1_rdata;

    logic              ctrl_req;
    logic              ctrl_we;
    logic [ADDR_W-1:0] ctrl_addr;
    logic [DATA_W-1:0] ctrl_wdata;
    logic [1:0]        ctrl_bsel;
    logic              ctrl_ack;
    logic              ctrl_done;
    logic [DATA_W-1:0] ctrl_rdata;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata, p0_bsel,
        output p0_ack, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_bsel,
        output p1_ack, p1_rdata,
        output ctrl_req, ctrl_we, ctrl_addr, ctrl_wdata, ctrl_bsel,
        input  ctrl_ack, ctrl_done, ctrl_rdata
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata, p0_bsel,
        input  p0_ack, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_bsel,
        input  p1_ack, p1_rdata,
        input  ctrl_req, ctrl_we, ctrl_addr, ctrl_wdata, ctrl_bsel,
        output ctrl_ack, ctrl_done, ctrl_rdata
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between the guest core (port 0) and the upload path (port 1).
// Round-robin by default; define SDRAM_ARB_P0_PRIORITY_EN for strict port-0 priority.
module sdram_port_arbiter #(
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sdram_port_arbiter_if.slave  bus,
    output logic                 timeout_err,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_t            state, state_n;
    logic              grant;        // 0 = port 0 owns the current transaction
    logic              last_grant;
    logic              pick;
    logic              take;
    logic              finish_ok;
    logic              finish_to;
    logic [CNT_W-1:0]  cnt;

    logic              ctrl_we_q;
    logic [ADDR_W-1:0] ctrl_addr_q;
    logic [DATA_W-1:0] ctrl_wdata_q;
    logic [1:0]        ctrl_bsel_q;
    logic [DATA_W-1:0] p0_rdata_q;
    logic [DATA_W-1:0] p1_rdata_q;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_n   = state;
        pick      = grant;
        take      = 1'b0;
        finish_ok = 1'b0;
        finish_to = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.p0_req || bus.p1_req) begin
                    take    = 1'b1;
                    state_n = ISSUE;
                    if (bus.p0_req && bus.p1_req) begin
`ifdef SDRAM_ARB_P0_PRIORITY_EN
                        pick = 1'b0;
`else
                        pick = ~last_grant;
`endif
                    end else begin
                        pick = bus.p1_req;
                    end
                end
            end
            ISSUE: begin
                if (bus.ctrl_ack) state_n = WAIT;
            end
            WAIT: begin
                // Completion beats a timeout landing on the same cycle.
                if (bus.ctrl_done) begin
                    finish_ok = 1'b1;
                    state_n   = HOLD;
                end else if (TIMEOUT != 0 && cnt == CNT_W'(TO_LAST)) begin
                    finish_to = 1'b1;
                    state_n   = HOLD;
                end
            end
            HOLD: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            cnt          <= '0;
            ctrl_we_q    <= 1'b0;
            ctrl_addr_q  <= '0;
            ctrl_wdata_q <= '0;
            ctrl_bsel_q  <= '0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state <= state_n;

            if (take) begin
                grant        <= pick;
                ctrl_we_q    <= pick ? bus.p1_we    : bus.p0_we;
                ctrl_addr_q  <= pick ? bus.p1_addr  : bus.p0_addr;
                ctrl_wdata_q <= pick ? bus.p1_wdata : bus.p0_wdata;
                ctrl_bsel_q  <= pick ? bus.p1_bsel  : bus.p0_bsel;
            end

            if (state == ISSUE)     cnt <= '0;
            else if (state == WAIT) cnt <= cnt + CNT_W'(1);

            if (finish_ok) begin
                if (grant) p1_rdata_q <= bus.ctrl_rdata;
                else       p0_rdata_q <= bus.ctrl_rdata;
            end

            if (finish_to) begin
                timeout_err <= 1'b1;
                if (grant) p1_rdata_q <= '0;
                else       p0_rdata_q <= '0;
            end

            if (state == HOLD) last_grant <= grant;
        end
    end

    assign bus.ctrl_req   = (state == ISSUE);
    assign bus.ctrl_we    = ctrl_we_q;
    assign bus.ctrl_addr  = ctrl_addr_q;
    assign bus.ctrl_wdata = ctrl_wdata_q;
    assign bus.ctrl_bsel  = ctrl_bsel_q;
    assign bus.p0_ack     = (state == HOLD) && !grant;
    assign bus.p1_ack     = (state == HOLD) &&  grant;
    assign bus.p0_rdata   = p0_rdata_q;
    assign bus.p1_rdata   = p1_rdata_q;
    assign busy           = (state != IDLE);
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sdram_port_arbiter;
    localparam int ADDR_W  = 25;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic reset_n;
    logic timeout_err;
    logic busy;

    int checks = 0;
    int errors = 0;

    sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int              m_cyc   = 0;
    bit              m_valid = 1'b0;
    bit              m_open, m_acc, m_hold;
    int              m_port, m_last, m_tacc;
    bit              m_terr;
    logic            m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [1:0]      m_bsel;
    logic [DATA_W-1:0] m_rdata [2];

    task automatic model_step();
        m_cyc++;
        if (!reset_n) begin
            m_valid = 1'b1; m_open = 1'b0; m_acc = 1'b0; m_hold = 1'b0;
            m_port = 0; m_last = 1; m_terr = 1'b0;
            m_we = 1'b0; m_addr = '0; m_wdata = '0; m_bsel = '0;
            m_rdata[0] = '0; m_rdata[1] = '0;
            return;
        end
        if (m_hold) begin
            m_hold = 1'b0; m_open = 1'b0; m_last = m_port;
        end else if (!m_open) begin
            if (bus.p0_req || bus.p1_req) begin
                if (bus.p0_req && bus.p1_req) begin
`ifdef SDRAM_ARB_P0_PRIORITY_EN
                    m_port = 0;
`else
                    m_port = 1 - m_last;
`endif
                end else begin
                    m_port = bus.p1_req ? 1 : 0;
                end
                m_open  = 1'b1;
                m_acc   = 1'b0;
                m_we    = (m_port == 1) ? bus.p1_we    : bus.p0_we;
                m_addr  = (m_port == 1) ? bus.p1_addr  : bus.p0_addr;
                m_wdata = (m_port == 1) ? bus.p1_wdata : bus.p0_wdata;
                m_bsel  = (m_port == 1) ? bus.p1_bsel  : bus.p0_bsel;
            end
        end else if (!m_acc) begin
            if (bus.ctrl_ack) begin
                m_acc = 1'b1; m_tacc = m_cyc;
            end
        end else if (bus.ctrl_done) begin
            m_rdata[m_port] = bus.ctrl_rdata; m_hold = 1'b1;
        end else if (TIMEOUT > 0 && m_cyc - m_tacc == TIMEOUT) begin
            m_rdata[m_port] = '0; m_terr = 1'b1; m_hold = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle compare and ack log ----------------
    int grant_log[$];
    int ack_count = 0;

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("ctrl_req",    32'(bus.ctrl_req),   32'(m_open && !m_acc && !m_hold));
            check("busy",        32'(busy),           32'(m_open));
            check("p0_ack",      32'(bus.p0_ack),     32'(m_hold && m_port == 0));
            check("p1_ack",      32'(bus.p1_ack),     32'(m_hold && m_port == 1));
            check("ctrl_we",     32'(bus.ctrl_we),    32'(m_we));
            check("ctrl_addr",   32'(bus.ctrl_addr),  32'(m_addr));
            check("ctrl_wdata",  32'(bus.ctrl_wdata), 32'(m_wdata));
            check("ctrl_bsel",   32'(bus.ctrl_bsel),  32'(m_bsel));
            check("p0_rdata",    32'(bus.p0_rdata),   32'(m_rdata[0]));
            check("p1_rdata",    32'(bus.p1_rdata),   32'(m_rdata[1]));
            check("timeout_err", 32'(timeout_err),    32'(m_terr));
        end
        if (bus.p0_ack === 1'b1) begin grant_log.push_back(0); ack_count++; end
        if (bus.p1_ack === 1'b1) begin grant_log.push_back(1); ack_count++; end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait (bounded) for ctrl_req, then accept immediately and complete the next cycle.
    task automatic serve(input logic [DATA_W-1:0] rd);
        int waited = 0;
        while (bus.ctrl_req !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (bus.ctrl_req !== 1'b1) begin
            check("ctrl_req_wait", 32'(bus.ctrl_req), 32'd1);
            return;
        end
        bus.ctrl_ack = 1'b1;
        tick();
        bus.ctrl_ack   = 1'b0;
        bus.ctrl_done  = 1'b1;
        bus.ctrl_rdata = rd;
        tick();
        bus.ctrl_done = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acks_before;
        int exp_order[4];

        reset_n = 1'b0;
        bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_wdata = '0; bus.p0_bsel = '0;
        bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_wdata = '0; bus.p1_bsel = '0;
        bus.ctrl_ack = 0; bus.ctrl_done = 0; bus.ctrl_rdata = '0;
        tick(2);
        reset_n = 1'b1;

        // Reset state
        check("rst busy",     32'(busy),         32'd0);
        check("rst ctrl_req", 32'(bus.ctrl_req), 32'd0);
        check("rst terr",     32'(timeout_err),  32'd0);
        check("rst p0_rdata", 32'(bus.p0_rdata), 32'd0);

        // Single read on port 0: ctrl_ack at T+1, ctrl_done at T+3, ack at T+4
        bus.p0_addr = 25'h000123; bus.p0_we = 1'b0; bus.p0_req = 1'b1;   // T
        tick();                                                           // T+1
        check("rd ctrl_req",  32'(bus.ctrl_req),  32'd1);
        check("rd ctrl_addr", 32'(bus.ctrl_addr), 32'h000123);
        bus.ctrl_ack = 1'b1;
        tick();                                                           // T+2
        bus.ctrl_ack = 1'b0;
        check("rd ctrl_req drop", 32'(bus.ctrl_req), 32'd0);
        tick();                                                           // T+3
        bus.ctrl_done = 1'b1; bus.ctrl_rdata = 16'hBEEF;
        tick();                                                           // T+4
        bus.ctrl_done = 1'b0;
        check("rd p0_ack",   32'(bus.p0_ack),   32'd1);
        check("rd p0_rdata", 32'(bus.p0_rdata), 32'hBEEF);
        check("rd p1_ack",   32'(bus.p1_ack),   32'd0);
        bus.p0_req = 1'b0;
        tick();                                                           // T+5
        check("rd ack pulse", 32'(bus.p0_ack), 32'd0);
        check("rd idle",      32'(busy),       32'd0);

        // Contention: both ports held high, four back-to-back transactions
        do_reset();
        grant_log.delete();
        bus.p0_addr = 25'h0000A0; bus.p1_addr = 25'h0000B1;
        bus.p0_req = 1'b1; bus.p1_req = 1'b1;
        for (int i = 0; i < 4; i++) serve(16'h1000 + 16'(i));
        bus.p0_req = 1'b0; bus.p1_req = 1'b0;
        tick(2);
`ifdef SDRAM_ARB_P0_PRIORITY_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        check("cont count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < grant_log.size()) check("cont order", 32'(grant_log[i]), 32'(exp_order[i]));

        // Write passthrough on port 1; request fields sampled only in IDLE
        bus.p1_addr = 25'h1ABCDE; bus.p1_we = 1'b1; bus.p1_wdata = 16'h55AA; bus.p1_bsel = 2'b01;
        bus.p1_req = 1'b1;
        tick();
        check("wr ctrl_we",    32'(bus.ctrl_we),    32'd1);
        check("wr ctrl_wdata", 32'(bus.ctrl_wdata), 32'h55AA);
        check("wr ctrl_bsel",  32'(bus.ctrl_bsel),  32'b01);
        bus.p1_wdata = 16'h0000; bus.p1_bsel = 2'b10;
        tick();
        check("wr wdata stable", 32'(bus.ctrl_wdata), 32'h55AA);
        bus.ctrl_ack = 1'b1;
        tick();
        bus.ctrl_ack = 1'b0; bus.ctrl_done = 1'b1; bus.ctrl_rdata = 16'h0F0F;
        tick();
        bus.ctrl_done = 1'b0;
        check("wr p1_ack", 32'(bus.p1_ack), 32'd1);
        bus.p1_req = 1'b0; bus.p1_we = 1'b0;
        tick();

        // Timeout: ctrl_done never arrives
        bus.p0_addr = 25'h000042; bus.p0_req = 1'b1;
        tick();
        bus.ctrl_ack = 1'b1;
        tick();                       // WAIT cycle 1
        bus.ctrl_ack = 1'b0;
        tick(7);                      // WAIT cycle 8
        check("to no ack yet", 32'(bus.p0_ack), 32'd0);
        tick();
        check("to p0_ack",   32'(bus.p0_ack),   32'd1);
        check("to p0_rdata", 32'(bus.p0_rdata), 32'd0);
        check("to terr",     32'(timeout_err),  32'd1);
        bus.p0_req = 1'b0;
        tick();
        bus.p1_addr = 25'h000055; bus.p1_req = 1'b1;
        serve(16'h1234);
        check("after to p1_ack",   32'(bus.p1_ack),   32'd1);
        check("after to p1_rdata", 32'(bus.p1_rdata), 32'h1234);
        check("terr sticky",       32'(timeout_err),  32'd1);
        bus.p1_req = 1'b0;
        tick();

        // Reset in WAIT: transaction abandoned, late ctrl_done ignored
        bus.p0_addr = 25'h000777; bus.p0_req = 1'b1;
        tick();
        bus.ctrl_ack = 1'b1;
        tick();
        bus.ctrl_ack = 1'b0;
        tick();
        bus.p0_req = 1'b0;
        acks_before = ack_count;
        do_reset();
        check("mid rst busy",      32'(busy),          32'd0);
        check("mid rst ctrl_req",  32'(bus.ctrl_req),  32'd0);
        check("mid rst ctrl_addr", 32'(bus.ctrl_addr), 32'd0);
        check("mid rst terr",      32'(timeout_err),   32'd0);
        check("mid rst p1_rdata",  32'(bus.p1_rdata),  32'd0);
        bus.ctrl_done = 1'b1; bus.ctrl_rdata = 16'hDEAD;
        tick();
        bus.ctrl_done = 1'b0;
        tick(2);
        check("mid rst no ack",   32'(ack_count),     32'(acks_before));
        check("mid rst p0_rdata", 32'(bus.p0_rdata),  32'd0);

        // ctrl_done on the timeout cycle; req dropped after grant
        bus.p1_addr = 25'h000999; bus.p1_req = 1'b1;
        tick();
        bus.p1_req = 1'b0;
        bus.ctrl_ack = 1'b1;
        tick();                       // WAIT cycle 1
        bus.ctrl_ack = 1'b0;
        tick(7);                      // WAIT cycle 8
        bus.ctrl_done = 1'b1; bus.ctrl_rdata = 16'hCAFE;
        tick();
        bus.ctrl_done = 1'b0;
        check("edge p1_ack",   32'(bus.p1_ack),   32'd1);
        check("edge p1_rdata", 32'(bus.p1_rdata), 32'hCAFE);
        check("edge terr",     32'(timeout_err),  32'd0);
        tick();
        check("edge idle", 32'(busy), 32'd0);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
